// File: rtl/vga_test_pattern_gen.sv
// vga_test_pattern_gen: regenerates col/row from raw HSync/VSync and emits
// RGB test patterns, with syncs delayed two cycles to stay pixel-aligned.
// Optional moving box for pattern 7: define PATTERN_MOVING_BOX_EN.
module vga_test_pattern_gen #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int BOX_SIZE    = 32
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [3:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam int CW    = $clog2(TOTAL_COLS);
  localparam int RW    = $clog2(TOTAL_ROWS);
  localparam int BAR_W = ACTIVE_COLS / 8;
  localparam int BCW   = $clog2(BAR_W + 1);
  localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

  // stage 1: counters, latched pattern, first sync delay
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [3:0]     pat_q;
  logic           fvalid_q;
  logic [BCW-1:0] bar_cnt_q;
  logic [2:0]     bar_idx_q;
  logic           hs1_q, vs1_q;

  // stage 2: output registers
  logic                   hs2_q, vs2_q;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
  logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

  logic frame_start;
  logic col_wrap;

  // vs1_q doubles as the registered copy used for edge detection
  assign frame_start = i_VSync & ~vs1_q;
  assign col_wrap    = (col_q == CW'(TOTAL_COLS - 1));

  // Stage 1: pixel position tracking; an early frame start overrides the wrap
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_q     <= '0;
      row_q     <= '0;
      pat_q     <= '0;
      fvalid_q  <= 1'b0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
    end else begin
      hs1_q <= i_HSync;
      vs1_q <= i_VSync;
      if (frame_start) begin
        col_q    <= '0;
        row_q    <= '0;
        pat_q    <= i_Pattern;
        fvalid_q <= 1'b1;
      end else if (col_wrap) begin
        col_q <= '0;
        row_q <= (row_q == RW'(TOTAL_ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
      // bar index tracks col without a divider; holds at the last bar
      if (frame_start || col_wrap) begin
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
      end else if (bar_cnt_q == BCW'(BAR_W - 1)) begin
        bar_cnt_q <= '0;
        if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 1'b1;
      end else begin
        bar_cnt_q <= bar_cnt_q + 1'b1;
      end
    end
  end

`ifdef PATTERN_MOVING_BOX_EN
  logic [CW-1:0] box_x_q;
  logic [RW-1:0] box_y_q;
  logic          box_dx_q, box_dy_q;
  logic          in_box;

  // Box steps once per completed frame, bouncing off the active-area edges
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      box_x_q  <= '0;
      box_y_q  <= '0;
      box_dx_q <= 1'b1;
      box_dy_q <= 1'b1;
    end else if (frame_start && fvalid_q) begin
      if (box_dx_q) begin
        if (box_x_q == CW'(ACTIVE_COLS - BOX_SIZE)) begin
          box_dx_q <= 1'b0;
          box_x_q  <= box_x_q - 1'b1;
        end else begin
          box_x_q <= box_x_q + 1'b1;
        end
      end else begin
        if (box_x_q == '0) begin
          box_dx_q <= 1'b1;
          box_x_q  <= box_x_q + 1'b1;
        end else begin
          box_x_q <= box_x_q - 1'b1;
        end
      end
      if (box_dy_q) begin
        if (box_y_q == RW'(ACTIVE_ROWS - BOX_SIZE)) begin
          box_dy_q <= 1'b0;
          box_y_q  <= box_y_q - 1'b1;
        end else begin
          box_y_q <= box_y_q + 1'b1;
        end
      end else begin
        if (box_y_q == '0) begin
          box_dy_q <= 1'b1;
          box_y_q  <= box_y_q + 1'b1;
        end else begin
          box_y_q <= box_y_q - 1'b1;
        end
      end
    end
  end

  assign in_box = (col_q >= box_x_q) &&
                  ({1'b0, col_q} < ({1'b0, box_x_q} + (CW+1)'(BOX_SIZE))) &&
                  (row_q >= box_y_q) &&
                  ({1'b0, row_q} < ({1'b0, box_y_q} + (RW+1)'(BOX_SIZE)));
`else
  logic unused_box;
  assign unused_box = (BOX_SIZE != 0);
`endif

  // Pattern colour for the stage-1 pixel; blank outside active area or before first frame
  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (fvalid_q && (col_q < CW'(ACTIVE_COLS)) && (row_q < RW'(ACTIVE_ROWS))) begin
      case (pat_q)
        4'd1: red_d = FULL;
        4'd2: grn_d = FULL;
        4'd3: blu_d = FULL;
        4'd4: if (!(col_q[5] ^ row_q[5])) begin
          red_d = FULL;
          grn_d = FULL;
          blu_d = FULL;
        end
        4'd5: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          red_d = {VIDEO_WIDTH{~bar_idx_q[1]}};
          grn_d = {VIDEO_WIDTH{~bar_idx_q[2]}};
          blu_d = {VIDEO_WIDTH{~bar_idx_q[0]}};
        end
        4'd6: if ((col_q == '0) || (col_q == CW'(ACTIVE_COLS - 1)) ||
                  (row_q == '0) || (row_q == RW'(ACTIVE_ROWS - 1))) begin
          red_d = FULL;
          grn_d = FULL;
          blu_d = FULL;
        end
`ifdef PATTERN_MOVING_BOX_EN
        4'd7: begin
          red_d = in_box ? FULL : '0;
          grn_d = in_box ? FULL : '0;
          blu_d = FULL;
        end
`endif
        default: ;
      endcase
    end
  end

  // Stage 2: register video and second sync delay together
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign o_HSync     = hs2_q;
  assign o_VSync     = vs2_q;
  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
module tb_vga_test_pattern_gen;
  localparam int VW  = 3;
  localparam int TC  = 80;
  localparam int TR  = 44;
  localparam int AC  = 64;
  localparam int AR  = 36;
  localparam int BOX = 8;

  logic clk = 1'b0;
  logic rst, hs_in, vs_in;
  logic [3:0] pat_in;
  logic hs_out, vs_out;
  logic [VW-1:0] red, grn, blu;

  always #5 clk = ~clk;

  vga_test_pattern_gen #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .BOX_SIZE(BOX)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_in), .i_VSync(vs_in),
    .i_Pattern(pat_in), .o_HSync(hs_out), .o_VSync(vs_out),
    .o_Red_Video(red), .o_Grn_Video(grn), .o_Blu_Video(blu)
  );

  typedef struct packed {
    logic hs;
    logic vs;
    logic [VW-1:0] r;
    logic [VW-1:0] g;
    logic [VW-1:0] b;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int popped = 0;
  bit done = 1'b0;

  bit m_prev_vs, m_valid;
  int m_n, m_steps;
  logic [3:0] m_pat;

  int gen_col, gen_row;
  logic drv_rst;
  logic [3:0] drv_pat;
  int plist[6] = '{5, 4, 6, 7, 0, 2};

  function automatic logic [2:0] bar_rgb(int bar);
    case (bar)
      0: return 3'b111;
      1: return 3'b110;
      2: return 3'b011;
      3: return 3'b010;
      4: return 3'b101;
      5: return 3'b100;
      6: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int tri_pos(int steps, int lim);
    int p;
    p = steps % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic exp_t pixel(int col, int row);
    exp_t e;
    logic [VW-1:0] f;
    logic [2:0] c;
    e = '0;
    f = '1;
    if (!m_valid || col >= AC || row >= AR) return e;
    case (m_pat)
      4'd1: e.r = f;
      4'd2: e.g = f;
      4'd3: e.b = f;
      4'd4: if (((col / 32) + (row / 32)) % 2 == 0) begin e.r = f; e.g = f; e.b = f; end
      4'd5: begin
        c = bar_rgb(col / (AC / 8));
        e.r = c[2] ? f : '0;
        e.g = c[1] ? f : '0;
        e.b = c[0] ? f : '0;
      end
      4'd6: if (col == 0 || col == AC - 1 || row == 0 || row == AR - 1) begin
        e.r = f; e.g = f; e.b = f;
      end
`ifdef PATTERN_MOVING_BOX_EN
      4'd7: begin
        int bx, by;
        bx = tri_pos(m_steps, AC - BOX);
        by = tri_pos(m_steps, AR - BOX);
        e.b = f;
        if (col >= bx && col < bx + BOX && row >= by && row < by + BOX) begin
          e.r = f; e.g = f;
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    logic h, v;
    @(negedge clk);
    h = (gen_col < AC);
    v = (gen_row < AR);
    rst = drv_rst;
    hs_in = h;
    vs_in = v;
    pat_in = drv_pat;
    if (drv_rst) begin
      if (q.size() > 0) q[$] = '0;
      q.push_back('0);
      m_prev_vs = 1'b0;
      m_valid = 1'b0;
      m_steps = 0;
      m_n = 0;
    end else begin
      if (v && !m_prev_vs) begin
        if (m_valid) m_steps++;
        m_valid = 1'b1;
        m_n = 0;
        m_pat = drv_pat;
      end else begin
        m_n++;
      end
      m_prev_vs = v;
      e = pixel(m_n % TC, (m_n / TC) % TR);
      e.hs = h;
      e.vs = v;
      q.push_back(e);
    end
    gen_col++;
    if (gen_col == TC) begin
      gen_col = 0;
      gen_row++;
      if (gen_row == TR) gen_row = 0;
    end
  endtask

  task automatic run_cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_rows(int n);
    run_cycles(n * TC);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (q.size() >= 2) begin
        e = q.pop_front();
        tests++;
        if (hs_out !== e.hs || vs_out !== e.vs || red !== e.r || grn !== e.g || blu !== e.b) begin
          fails++;
          if (fails <= 20)
            $display("FAIL pixel[%0d]: got hs=%b vs=%b rgb=(%0d,%0d,%0d) expected hs=%b vs=%b rgb=(%0d,%0d,%0d)",
                     popped, hs_out, vs_out, red, grn, blu, e.hs, e.vs, e.r, e.g, e.b);
        end
        popped++;
      end
    end
  end

  initial begin
    #2ms;
    if (!done) begin
      fails++;
      $display("FAIL timeout: stimulus did not complete, %0d pixels checked", popped);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; hs_in = 1'b0; vs_in = 1'b0; pat_in = 4'd0;
    m_prev_vs = 1'b0; m_valid = 1'b0; m_n = 0; m_steps = 0; m_pat = 4'd0;
    gen_col = 0; gen_row = 20;
    drv_rst = 1'b1; drv_pat = 4'd1;
    run_cycles(5);
    tests++;
    if (hs_out !== 1'b0 || vs_out !== 1'b0 || red !== '0 || grn !== '0 || blu !== '0) begin
      fails++;
      $display("FAIL reset state: hs=%b vs=%b rgb=(%0d,%0d,%0d)", hs_out, vs_out, red, grn, blu);
    end
    drv_rst = 1'b0;
    run_rows(24);
    run_rows(10);
    drv_pat = 4'd3;
    run_rows(34);
    run_rows(TR);
    for (int i = 0; i < 6; i++) begin
      drv_pat = plist[i][3:0];
      run_rows(TR);
    end
    drv_pat = 4'd6;
    run_rows(20);
    gen_row = TR - 1;
    gen_col = 0;
    run_rows(1 + TR);
    drv_pat = 4'd5;
    run_rows(10);
    drv_rst = 1'b1;
    run_cycles(3);
    drv_rst = 1'b0;
    run_rows(TR + 10);
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        drv_pat = 4'($urandom_range(0, 15));
        run_cycles($urandom_range(5 * TC, 11 * TC));
        if ($urandom_range(0, 5) == 0) begin
          gen_row = TR - 1;
          gen_col = $urandom_range(0, TC - 1);
        end
      end
    end
    run_rows(2);
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_test_pattern_gen.md
Name: vga_test_pattern_gen

Overview:
- Upstream video source for the porch stage.
- Consumes raw active-high HSync/VSync from the sync-pulse generator (HSync high while col < ACTIVE_COLS, VSync high while row < ACTIVE_ROWS).
- Regenerates column/row counters and produces RGB test patterns, with syncs delayed to stay pixel-aligned with the video.
- The outputs drive the porch module's sync/video inputs directly.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel; full intensity = all ones.
- TOTAL_COLS, 800, pixels per line including blanking.
- TOTAL_ROWS, 525, lines per frame including blanking.
- ACTIVE_COLS, 640, visible pixels per line; must be a multiple of 8.
- ACTIVE_ROWS, 480, visible lines per frame.
- BOX_SIZE, 32, moving-box edge length in pixels (used only with the optional feature).

Ports:
- i_Clk  in  1  pixel clock; sole clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_HSync  in  1  raw horizontal sync from the sync-pulse generator.
- i_VSync  in  1  raw vertical sync from the sync-pulse generator.
- i_Pattern  in  4  pattern select; sampled only at frame start.
- o_HSync  out  1  i_HSync delayed 2 cycles.
- o_VSync  out  1  i_VSync delayed 2 cycles.
- o_Red_Video  out  VIDEO_WIDTH  red channel, aligned to o_HSync/o_VSync.
- o_Grn_Video  out  VIDEO_WIDTH  green channel, aligned to o_HSync/o_VSync.
- o_Blu_Video  out  VIDEO_WIDTH  blue channel, aligned to o_HSync/o_VSync.

Behaviour:
- Reset (synchronous, i_Rst=1 at a clock edge) clears:
  - all outputs to 0;
  - the col/row counters, sync delay registers, latched pattern and frame-valid flag to 0.
- Frame start = rising edge of i_VSync, detected against a 1-cycle registered copy.
- Stage 1 (counters):
  - On frame start: col<=0, row<=0, latched pattern <= i_Pattern, frame-valid <= 1.
  - Otherwise col increments; at TOTAL_COLS-1 col wraps to 0 and row increments; at TOTAL_ROWS-1 (on col wrap) row wraps to 0.
- Stage 2 (video): RGB is registered from stage-1 col/row and the latched pattern.
- Latency: sample k of i_HSync/i_VSync appears on o_HSync/o_VSync at cycle k+2. The pixel for (col 0, row 0) appears in the same cycle as the o_VSync rising edge.
- Video is forced to 0 when any of the following holds: col >= ACTIVE_COLS, row >= ACTIVE_ROWS, or frame-valid = 0 (i.e. before the first frame start after reset).
- Patterns, by latched select value (channel value F = full intensity, 0 = off):
  - 0: black.
  - 1: red = F.
  - 2: green = F.
  - 3: blue = F.
  - 4: checkerboard; white when col[5]^row[5]=0, else black.
  - 5: eight vertical colour bars, each ACTIVE_COLS/8 wide, in order: white, yellow, cyan, green, magenta, red, blue, black. Bar index comes from a bar-width counter, with no divider.
  - 6: 1-pixel white border on col 0, col ACTIVE_COLS-1, row 0 and row ACTIVE_ROWS-1; interior black.
  - 7: moving box (see Optional Feature).
  - 8-15: black.
- An i_Pattern change mid-frame is ignored until the next frame start; no tearing.
- If i_VSync rises again before row reaches TOTAL_ROWS-1, counters realign immediately (an early frame start wins over the wrap).
- Reset asserted mid-frame: video stays 0 until the next frame start after reset releases.

Optional Feature:
- Macro: PATTERN_MOVING_BOX_EN.
- Defined:
  - Adds box registers x, y (reset 0) and direction bits dx, dy (reset +1).
  - At each frame start, x and y step by ±1 per their direction.
  - x direction reverses when x+BOX_SIZE = ACTIVE_COLS (moving +) or x = 0 (moving −); y likewise against ACTIVE_ROWS.
  - Pattern 7 draws a white box at [x, x+BOX_SIZE) × [y, y+BOX_SIZE) on a blue background.
- Undefined: no box logic is instantiated and pattern 7 outputs black.

Test Plan:
- Reset, then a 640x480 sync stream with i_Pattern=1 → all RGB = 0 before the first VSync rise; afterwards red=7 and green=blue=0 on active pixels, and RGB = 0 at col 640-799 and rows 480-524.
- i_VSync rises at cycle T → o_VSync rises at T+2, with o_Red_Video=7 (col 0, row 0) in the same cycle; o_HSync equals i_HSync delayed by exactly 2 cycles throughout.
- i_Pattern=5 → col 0-79 RGB=(7,7,7); col 80 (7,7,0); col 160 (0,7,7); col 560-639 (0,0,0); col 640 (0,0,0).
- i_Pattern=4 → (col 31, row 0) white; (col 32, row 0) black; (col 32, row 32) white.
- i_Pattern switched 1→3 at row 100 → red for the rest of that frame; the next frame is blue from (col 0, row 0).
- With PATTERN_MOVING_BOX_EN and i_Pattern=7 → box origin is (0,0) in frame 1, (1,1) in frame 2, and reaches x=608 in frame 609 after which x decreases; without the macro → RGB = 0 everywhere.
